// File: rtl/fp_round_if.sv
// Handshake bundle for the linear-to-float rounding encoder.
// Carries the input sample channel and the sign/exponent/significand result channel.
// master = sample producer / result consumer side, slave = encoder side.
// Ports: in_valid/in_ready/in_data (sample), out_valid/out_ready/out_sign/out_exp/out_sig/out_sat (result).
interface fp_round_if #(
    parameter int DATA_W = 12,
    parameter int EXP_W  = 3,
    parameter int SIG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [SIG_W-1:0]  out_sig;
    logic              out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
    );
endinterface

// File: rtl/fp_round_pipe.sv
// Purpose: two's-complement sample -> sign / exponent / significand (value = F * 2^E), rounded, saturating.
// Latency: 3 cycles accept-to-out_valid (S1 sign/mag, S2 normalise, S3 round), 1 sample/cycle.
// Backpressure: per-stage valid, bubbles collapse, in_ready combinational from the downstream chain.
// Ports: clk, rst_n (synchronous, active-low), bus (fp_round_if.slave: in_* sample side, out_* result side).
// Build option: define FP_ROUND_RNE_EN for round-to-nearest-even; otherwise round-half-up.
module fp_round_pipe #(
    parameter int DATA_W = 12,
    parameter int EXP_W  = 3,
    parameter int SIG_W  = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    fp_round_if.slave bus
);
    localparam int MAG_W = DATA_W - 1;
    localparam int E_MAX = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] EXP_TOP   = '1;
    localparam logic [SIG_W-1:0] SIG_CARRY = {1'b1, {(SIG_W-1){1'b0}}};

    generate
        if ((DATA_W - 1 - SIG_W > E_MAX) || (SIG_W < 2)) begin : g_bad_cfg
            $error("fp_round_pipe: need DATA_W-1-SIG_W <= 2^EXP_W-1 and SIG_W >= 2");
        end
    endgenerate

    // ---------------------------------------------------------------
    // Stage flow control: a stage loads when empty or when it drains.
    // ---------------------------------------------------------------
    logic s1_vld, s2_vld, s3_vld;
    logic ld1, ld2, ld3;

    assign ld3          = !s3_vld || bus.out_ready;
    assign ld2          = !s2_vld || ld3;
    assign ld1          = !s1_vld || ld2;
    assign bus.in_ready = ld1;

    // ---------------------------------------------------------------
    // S1: sign / magnitude
    // ---------------------------------------------------------------
    logic             n1_sign;
    logic             n1_satp;
    logic [MAG_W-1:0] n1_mag;

    always_comb begin
        n1_sign = bus.in_data[DATA_W-1];
        n1_satp = 1'b0;
        n1_mag  = bus.in_data[MAG_W-1:0];
        if (n1_sign) begin
            if (bus.in_data[MAG_W-1:0] == '0) begin
                // Most-negative code has no positive twin: clamp and flag.
                n1_mag  = '1;
                n1_satp = 1'b1;
            end else begin
                // -x mod 2^MAG_W of the low bits equals |x| for any other negative x.
                n1_mag = MAG_W'(0) - bus.in_data[MAG_W-1:0];
            end
        end
    end

    logic             s1_sign;
    logic             s1_satp;
    logic [MAG_W-1:0] s1_mag;

    // ---------------------------------------------------------------
    // S2: normalise to SIG_W significant bits, capture round/sticky
    // ---------------------------------------------------------------
    int               lead;
    int               sh;
    logic [EXP_W-1:0] n2_exp;
    logic [SIG_W-1:0] n2_sig;
    logic             n2_rnd;
`ifdef FP_ROUND_RNE_EN
    logic             n2_stk;
    logic [MAG_W-1:0] stk_mask;
`endif

    always_comb begin
        lead = 0;
        for (int i = 0; i < MAG_W; i++) begin
            if (s1_mag[i]) lead = i;
        end
        sh     = 0;
        n2_exp = '0;
        n2_sig = s1_mag[SIG_W-1:0];
        n2_rnd = 1'b0;
`ifdef FP_ROUND_RNE_EN
        n2_stk   = 1'b0;
        stk_mask = '0;
`endif
        if ((s1_mag >> SIG_W) != '0) begin
            // Leading one sits above the significand field: shift it down to bit SIG_W-1.
            sh     = lead - SIG_W + 1;
            n2_exp = EXP_W'(sh);
            n2_sig = SIG_W'(s1_mag >> sh);
            n2_rnd = |(s1_mag & (MAG_W'(1) << (sh - 1)));
`ifdef FP_ROUND_RNE_EN
            stk_mask = (MAG_W'(1) << (sh - 1)) - MAG_W'(1);
            n2_stk   = |(s1_mag & stk_mask);
`endif
        end
    end

    logic             s2_sign;
    logic             s2_satp;
    logic [EXP_W-1:0] s2_exp;
    logic [SIG_W-1:0] s2_sig;
    logic             s2_rnd;
`ifdef FP_ROUND_RNE_EN
    logic             s2_stk;
`endif

    // ---------------------------------------------------------------
    // S3: round, carry into exponent, saturate at the top
    // ---------------------------------------------------------------
    logic             up;
    logic [EXP_W-1:0] n3_exp;
    logic [SIG_W-1:0] n3_sig;
    logic             n3_sat;

    always_comb begin
`ifdef FP_ROUND_RNE_EN
        up = s2_rnd && (s2_stk || s2_sig[0]);
`else
        up = s2_rnd;
`endif
        n3_exp = s2_exp;
        n3_sig = s2_sig;
        n3_sat = s2_satp;
        if (up) begin
            if (s2_sig != '1) begin
                n3_sig = s2_sig + SIG_W'(1);
            end else if (s2_exp != EXP_TOP) begin
                // Carry-out renormalises to 100..0 with the exponent bumped.
                n3_exp = s2_exp + EXP_W'(1);
                n3_sig = SIG_CARRY;
            end else begin
                // No room left: pin to the largest code.
                n3_sig = '1;
                n3_sat = 1'b1;
            end
        end
    end

    logic             s3_sign;
    logic [EXP_W-1:0] s3_exp;
    logic [SIG_W-1:0] s3_sig;
    logic             s3_sat;

    // ---------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_satp <= 1'b0;
            s1_mag  <= '0;
            s2_sign <= 1'b0;
            s2_satp <= 1'b0;
            s2_exp  <= '0;
            s2_sig  <= '0;
            s2_rnd  <= 1'b0;
`ifdef FP_ROUND_RNE_EN
            s2_stk  <= 1'b0;
`endif
            s3_sign <= 1'b0;
            s3_exp  <= '0;
            s3_sig  <= '0;
            s3_sat  <= 1'b0;
        end else begin
            if (ld1) s1_vld <= bus.in_valid;
            if (ld2) s2_vld <= s1_vld;
            if (ld3) s3_vld <= s2_vld;

            if (ld1 && bus.in_valid) begin
                s1_sign <= n1_sign;
                s1_satp <= n1_satp;
                s1_mag  <= n1_mag;
            end
            if (ld2 && s1_vld) begin
                s2_sign <= s1_sign;
                s2_satp <= s1_satp;
                s2_exp  <= n2_exp;
                s2_sig  <= n2_sig;
                s2_rnd  <= n2_rnd;
`ifdef FP_ROUND_RNE_EN
                s2_stk  <= n2_stk;
`endif
            end
            if (ld3 && s2_vld) begin
                s3_sign <= s2_sign;
                s3_exp  <= n3_exp;
                s3_sig  <= n3_sig;
                s3_sat  <= n3_sat;
            end
        end
    end

    assign bus.out_valid = s3_vld;
    assign bus.out_sign  = s3_sign;
    assign bus.out_exp   = s3_exp;
    assign bus.out_sig   = s3_sig;
    assign bus.out_sat   = s3_sat;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: directed latency/corner cases, backpressure, mid-stream reset,
// then randomized valid/ready traffic scored against an arithmetic reference model.
module tb_fp_round_pipe;
    localparam int DATA_W = 12;
    localparam int EXP_W  = 3;
    localparam int SIG_W  = 4;
    localparam int E_MAX  = (1 << EXP_W) - 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q[$];

    fp_round_if #(.DATA_W(DATA_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) bus ();

    fp_round_pipe #(.DATA_W(DATA_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pk(input bit s, input bit sat, input int e, input int f);
        return 32'({s, sat, EXP_W'(e), SIG_W'(f)});
    endfunction

    function automatic logic [31:0] obs();
        return 32'({bus.out_sign, bus.out_sat, bus.out_exp, bus.out_sig});
    endfunction

    // Reference: exact integer value, divide by 2^E, round on the remainder.
    function automatic logic [31:0] model(input logic [DATA_W-1:0] d);
        int v, m, e, q, rem, half;
        bit s, sat, up;
        s   = d[DATA_W-1];
        v   = s ? int'(d) - (1 << DATA_W) : int'(d);
        m   = (v < 0) ? -v : v;
        sat = 1'b0;
        if (m > (1 << (DATA_W - 1)) - 1) begin
            m   = (1 << (DATA_W - 1)) - 1;
            sat = 1'b1;
        end
        e = 0;
        while ((m >> e) >= (1 << SIG_W)) e++;
        q    = m >> e;
        rem  = m - (q << e);
        half = (e > 0) ? (1 << (e - 1)) : 0;
`ifdef FP_ROUND_RNE_EN
        up = (e > 0) && ((rem > half) || ((rem == half) && (q % 2 == 1)));
`else
        up = (e > 0) && (rem >= half);
`endif
        if (up) q = q + 1;
        if (q == (1 << SIG_W)) begin
            e = e + 1;
            q = 1 << (SIG_W - 1);
        end
        if (e > E_MAX) begin
            e   = E_MAX;
            q   = (1 << SIG_W) - 1;
            sat = 1'b1;
        end
        return pk(s, sat, e, q);
    endfunction

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(bus.out_valid), 32'd0);
        else check(tag, obs(), exp_q.pop_front());
    endtask

    // One sample into an idle pipe with out_ready=1; result must show on the 3rd edge.
    task automatic lat_test(input string tag, input logic [DATA_W-1:0] d, input logic [31:0] want);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_lat2"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_lat3"}, 32'(bus.out_valid), 32'd1);
        check(tag, obs(), want);
    endtask

    function automatic logic [DATA_W-1:0] rand_sample();
        logic [DATA_W-1:0] corner [8];
        corner = '{12'h000, 12'h7FF, 12'h800, 12'hFFF, 12'h0F8, 12'h0A8, 12'h001, 12'h7F8};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 7)];
        return DATA_W'($urandom);
    endfunction

    initial begin
        logic [DATA_W-1:0] bp [5];
        logic [31:0] snap;
        logic [31:0] hold_val;
        logic        hold_pend;
        logic        acc_last;
        int          sent;
        int          outs;
        int          outs_at2;

        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_data", obs(), 32'd0);
        rst_n = 1'b1;

        // Directed values
        lat_test("zero",   12'h000, pk(0, 0, 0, 4'b0000));
        lat_test("d422",   12'h1A6, pk(0, 0, 5, 4'b1101));
        lat_test("carry",  12'h0F8, pk(0, 0, 5, 4'b1000));
        lat_test("top",    12'h7FF, pk(0, 1, 7, 4'b1111));
        lat_test("mostneg",12'h800, pk(1, 1, 7, 4'b1111));
        lat_test("neg1",   12'hFFF, pk(1, 0, 0, 4'b0001));
`ifdef FP_ROUND_RNE_EN
        lat_test("tie",    12'h0A8, pk(0, 0, 4, 4'b1010));
`else
        lat_test("tie",    12'h0A8, pk(0, 0, 4, 4'b1011));
`endif
        lat_test("tie_odd",12'h0B8, pk(0, 0, 4, 4'b1100));

        // Backpressure: fill with out_ready=0
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        bp = '{12'h123, 12'hF00, 12'h0A8, 12'h7FF, 12'h055};
        bus.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sent < 5) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bp[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_data));
                sent++;
            end
        end
        check("bp_accepted", 32'(sent), 32'd3);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        snap = obs();
        repeat (2) @(negedge clk);
        check("bp_stable", obs(), snap);
        outs     = 0;
        outs_at2 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (sent < 5) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bp[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_data));
                sent++;
            end
            if (bus.out_valid) begin
                pop_check("bp_out");
                outs++;
            end
            if (c == 2) outs_at2 = outs;
        end
        check("bp_consec", 32'(outs_at2), 32'd3);
        check("bp_total", 32'(outs), 32'd5);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset with 3 samples in flight
        bus.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(12'h300 + c);
            #1;
            if (bus.in_ready) sent++;
        end
        check("rst_fill", 32'(sent), 32'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_data", obs(), 32'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("no_stale", 32'(bus.out_valid), 32'd0);
        end
        lat_test("post_rst", 12'h1A6, pk(0, 0, 5, 4'b1101));

        // Randomized traffic
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        hold_pend = 1'b0;
        acc_last  = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (hold_pend) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", obs(), hold_val);
            end
            hold_pend = 1'b0;
            if (acc_last || !bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = rand_sample();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc_last = bus.in_valid && bus.in_ready;
            if (acc_last) exp_q.push_back(model(bus.in_data));
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    pop_check("rand_out");
                end else begin
                    hold_pend = 1'b1;
                    hold_val  = obs();
                end
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.out_valid) pop_check("drain_out");
            @(negedge clk);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp_round_pipe.md
Name: fp_round_pipe

Overview:
- Parametrised, pipelined linear-to-floating-point encoder with rounding.
- Converts a two's-complement sample into sign / exponent / significand form.
- Handles round-up, mantissa carry-out into the exponent, and saturation at the top of the range.
- Sits between the sample source and the display/packing logic, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 12, input sample width (two's complement).
- EXP_W, 3, exponent width. E_MAX = 2^EXP_W - 1.
- SIG_W, 4, significand width. Constraint: DATA_W - 1 - SIG_W <= E_MAX and SIG_W >= 2; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset
- in_valid  in  1  input sample valid
- in_ready  out  1  stage 1 can accept
- in_data  in  DATA_W  two's-complement sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_sign  out  1  sign of sample
- out_exp  out  EXP_W  exponent E
- out_sig  out  SIG_W  significand F; value represented = F * 2^E
- out_sat  out  1  result saturated (overflow or most-negative input)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: in reset all stage-valid flags clear; out_valid=0, out_sign=0, out_exp=0, out_sig=0, out_sat=0.
- Reset mid-operation: any in-flight samples are discarded, with no partial outputs afterwards.
- Handshake:
  - Transfer occurs on a cycle where valid && ready.
  - out_* are held stable while out_valid=1 and out_ready=0.
- Pipeline: 3 register stages S1/S2/S3; S3 drives the out_* ports.
  - A stage loads when it is empty, or when its contents move on in the same cycle.
  - in_ready = S1 empty or S1 advancing (combinational from the downstream chain).
  - Latency 3 cycles from accept to out_valid with no backpressure; throughput 1 sample/cycle.
  - Order is preserved and no sample is dropped or duplicated.
  - Capacity is 3 samples; bubbles collapse.
- S1 (sign / magnitude):
  - sign = in_data[DATA_W-1].
  - mag = |in_data|, DATA_W-1 bits.
  - Most-negative input (only MSB set): mag = 2^(DATA_W-1)-1 and sat_pre=1.
- S2 (normalise):
  - p = index of the leading 1 in mag.
  - mag < 2^SIG_W: E=0, F=mag[SIG_W-1:0], r=0, sticky=0.
  - Otherwise: E = p-SIG_W+1, F = mag[p:p-SIG_W+1], r = mag[p-SIG_W], sticky = OR of mag[p-SIG_W-1:0] (0 if empty).
- S3 (round):
  - Round-up condition (default): up = r.
  - up=0: F unchanged.
  - up=1 and F not all ones: F=F+1.
  - up=1, F all ones, E<E_MAX: E=E+1, F=1 followed by SIG_W-1 zeros (e.g. 1000). A right-shifted 0111 is wrong.
  - up=1, F all ones, E=E_MAX: saturate; F all ones, E=E_MAX, out_sat=1.
  - out_sat = saturate OR sat_pre.
  - All arithmetic is unsigned at the stated widths; no wrap is ever visible on the outputs.

Optional Feature:
- Macro: FP_ROUND_RNE_EN.
- Defined: round-to-nearest-even. up = r && (sticky || F[0]).
- Undefined: round-half-up. up = r; sticky is unused and is optimised away.
- Carry and saturation rules are identical in both builds.

Test Plan:
- Default params, no backpressure, in_data=0x000 -> exactly 3 cycles later out_valid=1, sign=0, E=0, F=0000, sat=0.
- in_data=0x1A6 (422) -> E=5, F=1101, sat=0. Then 0x0F8 (248) -> carry: E=5, F=1000, sat=0.
- in_data=0x7FF -> E=7, F=1111, sat=1. in_data=0x800 -> sign=1, E=7, F=1111, sat=1. in_data=0xFFF (-1) -> sign=1, E=0, F=0001.
- Tie in_data=0x0A8:
  - without FP_ROUND_RNE_EN -> E=4, F=1011.
  - with FP_ROUND_RNE_EN -> E=4, F=1010.
  - 0x0B8 gives E=4, F=1100 in both builds.
- Backpressure: out_ready=0, feed 5 back-to-back samples -> exactly 3 accepted, then in_ready=0; out_* stable. Raise out_ready -> 3 results in input order on consecutive cycles, then the remaining 2.
- Reset mid-stream: pulse rst_n=0 for 1 cycle with 3 samples in flight -> next cycle out_valid=0 and all outputs 0. No stale result appears afterwards; a new sample emerges 3 cycles after acceptance.
